// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller slice.
package int_pkg;

  localparam int unsigned NSRC_DEFAULT     = 4;
  localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins.
module int_prio_enc
  import int_pkg::*;
#(
  parameter  int unsigned NSRC = NSRC_DEFAULT,
  localparam int unsigned IW   = idx_width(NSRC)
) (
  input  logic [NSRC-1:0] i_eligible,
  output logic [IW-1:0]   o_index,
  output logic            o_any_valid
);

  logic          w_found;
  logic [IW-1:0] w_index;

  always_comb begin
    w_found = 1'b0;
    w_index = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (i_eligible[i] && !w_found) begin
        w_found = 1'b1;
        w_index = IW'(i);
      end
    end
  end

  assign o_index     = w_index;
  assign o_any_valid = w_found;

endmodule

// File: rtl/int_controller.sv
// Edge-triggered, masked, non-nesting interrupt controller presenting one
// registered request/vector at a time to the CPU.
module int_controller
  import int_pkg::*;
#(
  parameter int unsigned NSRC     = NSRC_DEFAULT,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] mask_in,
  input  logic            mask_we,
  input  logic            gie,
  input  logic            int_ack,
  input  logic            int_done,
  output logic            int_req,
  output logic [15:0]     int_vec,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  localparam int unsigned IW = idx_width(NSRC);

  logic [NSRC-1:0] r_irq_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_sel;
  logic [IW-1:0]   w_sel_nxt;
  logic            r_int_req;
  logic [15:0]     r_int_vec;
  logic            w_req_nxt;
  logic [15:0]     w_vec_nxt;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_eligible;
  logic [NSRC-1:0] w_clr;
  logic [IW-1:0]   w_win_idx;
  logic            w_win_any;
  logic            w_ack_take;

  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_eligible = r_pending & r_mask;
  assign w_ack_take = (r_state == REQ) && int_ack;
  assign w_clr      = w_ack_take ? (NSRC'(1) << r_sel) : '0;

  int_prio_enc #(
    .NSRC (NSRC)
  ) u_prio (
    .i_eligible  (w_eligible),
    .o_index     (w_win_idx),
    .o_any_valid (w_win_any)
  );

  // irq_prev resets to all ones so a source already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_prev <= '1;
      r_pending  <= '0;
      r_mask     <= '0;
    end else begin
      r_irq_prev <= irq_in;
      // A fresh edge on the acknowledged source outranks the clear.
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) begin
        r_mask <= mask_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Once in REQ the request stays up regardless of gie or mask; only ack leaves it.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      IDLE: begin
        if (gie && w_win_any) begin
          w_state_nxt = REQ;
          w_sel_nxt   = w_win_idx;
        end
      end
      REQ: begin
        if (int_ack) begin
          w_state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered copy tracks REQ exactly.
  always_comb begin
    w_req_nxt = (w_state_nxt == REQ);
    w_vec_nxt = '0;
    if (w_req_nxt) begin
      w_vec_nxt = VEC_BASE + (16'(w_sel_nxt) << 2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_req <= 1'b0;
      r_int_vec <= '0;
    end else begin
      r_int_req <= w_req_nxt;
      r_int_vec <= w_vec_nxt;
    end
  end

  assign int_req = r_int_req;
  assign int_vec = r_int_vec;
  assign pending = r_pending;
  assign mask    = r_mask;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: expected vectors are queued by the
// stimulus and consumed by a monitor on each new int_req assertion.
module tb_int_controller;
  import int_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic [3:0]  mask_in;
  logic        mask_we;
  logic        gie;
  logic        int_ack;
  logic        int_done;
  logic        int_req;
  logic [15:0] int_vec;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        mon_en = 1'b0;
  logic        seen   = 1'b0;
  logic [15:0] exp_q[$];

  int_controller #(
    .NSRC     (4),
    .VEC_BASE (16'h0010)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .mask_in  (mask_in),
    .mask_we  (mask_we),
    .gie      (gie),
    .int_ack  (int_ack),
    .int_done (int_done),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .pending  (pending),
    .mask     (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_req_seen"}, 32'(int_req), 32'd1);
  endtask

  // Monitor: each rising int_req consumes one expected vector.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int_req === 1'b1 && !seen) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_req: got vec %0h expected none", int_vec);
        end else begin
          chk("int_vec", 32'(int_vec), 32'(exp_q.pop_front()));
        end
      end
      if (int_req !== 1'b1) begin
        chk("vec_zero_when_idle", 32'(int_vec), 32'd0);
      end
      seen = (int_req === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq_in = '0; mask_in = '0; mask_we = 1'b0;
    gie = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    tick(); tick(); tick();
    chk("rst_req",   32'(int_req), 32'd0);
    chk("rst_vec",   32'(int_vec), 32'd0);
    chk("rst_pend",  32'(pending), 32'd0);
    chk("rst_mask",  32'(mask),    32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    mon_en = 1'b1;

    // Timer pulse on source 0, two-cycle latency
    gie = 1'b1; mask_in = 4'b0001; mask_we = 1'b1; tick(); mask_we = 1'b0;
    chk("mask_load", 32'(mask), 32'h1);
    exp_q.push_back(16'h0010);
    irq_in = 4'b0001; tick(); irq_in = '0;
    chk("t1_pend",  32'(pending), 32'h1);
    chk("t1_lat1",  32'(int_req), 32'd0);
    tick();
    chk("t1_lat2",  32'(int_req), 32'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t1_pclr",  32'(pending), 32'h0);
    chk("t1_reqoff", 32'(int_req), 32'd0);
    chk("t1_svc",   32'(dut.r_state), 32'(SERVICE));
    repeat (3) tick();
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("t1_idle",  32'(dut.r_state), 32'(IDLE));

    // Priority: sources 1 and 2 together, 1 first then 2
    mask_in = 4'b1111; mask_we = 1'b1; tick(); mask_we = 1'b0;
    exp_q.push_back(16'h0014);
    exp_q.push_back(16'h0018);
    irq_in = 4'b0110; tick(); irq_in = '0;
    wait_req("t2a");
    chk("t2_pend",  32'(pending), 32'h6);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t2_pend1", 32'(pending), 32'h4);
    int_done = 1'b1; tick(); int_done = 1'b0;
    wait_req("t2b");
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("t2_pend2", 32'(pending), 32'h0);

    // Masked source and gie gating
    mask_in = 4'b0000; mask_we = 1'b1; tick(); mask_we = 1'b0;
    irq_in = 4'b1000; tick(); irq_in = '0;
    tick(); tick();
    chk("t3_pend",  32'(pending), 32'h8);
    chk("t3_noreq", 32'(int_req), 32'd0);
    gie = 1'b0; mask_in = 4'b1000; mask_we = 1'b1; tick(); mask_we = 1'b0;
    tick(); tick();
    chk("t3_mask",  32'(mask),    32'h8);
    chk("t3_gie0",  32'(int_req), 32'd0);
    exp_q.push_back(16'h001C);
    gie = 1'b1;
    wait_req("t3");
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("t3_pclr",  32'(pending), 32'h0);

    // Set/clear collision on source 1
    mask_in = 4'b0010; mask_we = 1'b1; tick(); mask_we = 1'b0;
    exp_q.push_back(16'h0014);
    exp_q.push_back(16'h0014);
    irq_in = 4'b0010; tick(); irq_in = '0;
    wait_req("t4a");
    irq_in = 4'b0010; int_ack = 1'b1; tick(); irq_in = '0; int_ack = 1'b0;
    chk("t4_setwins", 32'(pending), 32'h2);
    chk("t4_reqoff",  32'(int_req), 32'd0);
    int_done = 1'b1; tick(); int_done = 1'b0;
    wait_req("t4b");
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("t4_pclr", 32'(pending), 32'h0);

    // Stray handshakes
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_ack_idle",  32'(dut.r_state), 32'(IDLE));
    chk("t5_ack_pend",  32'(pending), 32'h0);
    exp_q.push_back(16'h0014);
    irq_in = 4'b0010; tick(); irq_in = '0;
    wait_req("t5");
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("t5_done_req",  32'(dut.r_state), 32'(REQ));
    chk("t5_done_ireq", 32'(int_req), 32'd1);
    chk("t5_done_pend", 32'(pending), 32'h2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_svc", 32'(dut.r_state), 32'(SERVICE));

    // Reset mid-SERVICE with sources held high through release
    irq_in = 4'b1111; rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_req",   32'(int_req), 32'd0);
    chk("t6_vec",   32'(int_vec), 32'd0);
    chk("t6_pend",  32'(pending), 32'h0);
    chk("t6_mask",  32'(mask),    32'h0);
    chk("t6_state", 32'(dut.r_state), 32'(IDLE));
    tick(); tick();
    chk("t6_noedge", 32'(pending), 32'h0);
    irq_in = '0;
    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources; source 0 is the timer's do_int.
REQ-002 Parameter VEC_BASE, default 16'h0010: address of the source-0 handler; each source's vector is 4 words apart.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port irq_in, input, NSRC: raw requests; bit 0 is driven by the timer's do_int pulse.
REQ-006 Port mask_in, input, NSRC: new mask value, where 1 = source enabled.
REQ-007 Port mask_we, input, 1: loads mask_in into the mask register.
REQ-008 Port gie, input, 1: CPU global interrupt enable.
REQ-009 Port int_ack, input, 1: CPU accepts the presented interrupt.
REQ-010 Port int_done, input, 1: CPU returned from the handler (reti).
REQ-011 Port int_req, output, 1: interrupt request to the CPU.
REQ-012 Port int_vec, output, 16: handler address, valid while int_req=1.
REQ-013 Port pending, output, NSRC: latched pending bits, readable by software.
REQ-014 Port mask, output, NSRC: current mask register.

Function
REQ-015 The block SHALL detect rising edges: edge[i] = irq_in[i] & ~irq_prev[i], where irq_prev is irq_in registered every cycle.
REQ-016 An edge SHALL set pending[i] at that clock edge, so pending[i] is visible the next cycle; this happens regardless of mask, gie or state.
REQ-017 Eligible sources SHALL be pending & mask; the winner is the lowest eligible index (index 0 has highest priority).
REQ-018 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-019 IDLE -> REQ SHALL occur when gie=1 and eligible != 0; on that edge the winner index is captured into sel, and int_req goes high the following cycle.
REQ-020 In REQ: int_req=1 and int_vec = VEC_BASE + (sel << 2); sel SHALL stay frozen even if a higher-priority source becomes pending.
REQ-021 REQ -> SERVICE SHALL occur on int_ack=1; on the same edge pending[sel] is cleared, unless a new edge on source sel occurs in that cycle, in which case set wins and pending[sel] stays 1.
REQ-022 In SERVICE: int_req=0; the block SHALL ignore further requests (no nesting).
REQ-023 SERVICE -> IDLE SHALL occur on int_done=1.
REQ-024 REQ SHALL be held while gie=0 or while mask[sel] is cleared; the request is never withdrawn once presented.
REQ-025 int_ack SHALL be ignored outside REQ, and int_done SHALL be ignored outside SERVICE.
REQ-026 mask_we SHALL update mask at the clock edge; the new value first affects eligibility the following cycle.
REQ-027 int_vec SHALL be 16'h0000 whenever int_req=0.
REQ-028 Vector arithmetic SHALL be 16-bit modulo, with no overflow detection.
REQ-029 Minimum latency SHALL be 2 cycles: an edge at cycle N gives pending at N+1 and int_req at N+2.

Reset
REQ-030 rst=1 SHALL force, at the next clock edge: state=IDLE, pending=0, mask=0, irq_prev=all ones (so no false edge on release), sel=0, int_req=0 and int_vec=0.
REQ-031 rst SHALL take priority over every other input, including when asserted mid-REQ or mid-SERVICE.

Structure
REQ-032 Package int_pkg SHALL hold the FSM state typedef (IDLE/REQ/SERVICE), NSRC_DEFAULT and VEC_BASE_DEFAULT.
REQ-033 The priority encoder SHALL be sub-module int_prio_enc, taking NSRC-bit eligible in and producing index plus any_valid out, purely combinational.
REQ-034 All outputs SHALL be registered except pending and mask, which are direct register reads.

Verification
REQ-035 Timer pulse: with mask=4'b0001 and gie=1, a 1-cycle pulse on irq_in[0] at cycle 10 -> int_req=1 with int_vec=16'h0010 at cycle 12; int_ack at 14 -> pending[0]=0 at 15; int_done at 20 -> state IDLE.
REQ-036 Priority: mask=4'b1111, edges on sources 2 and 1 in the same cycle -> int_vec=16'h0014; after ack+done, a second request appears with int_vec=16'h0018.
REQ-037 Masked and gie gating: source 3 edge with mask=0 -> pending=4'b1000 and int_req stays 0; then mask_we with 4'b1000 while gie=0 -> no request; raising gie -> int_req=1 with int_vec=16'h001C.
REQ-038 Set/clear collision: source 1 edge in the same cycle as int_ack for sel=1 -> pending[1] remains 1, and a new request follows after int_done.
REQ-039 Reset mid-SERVICE: rst for 1 cycle -> int_req=0, pending=0 and mask=0 next cycle; irq_in held high through rst release -> no pending set.
REQ-040 Stray handshakes: int_ack in IDLE and int_done in REQ -> no state change and pending unchanged.
